// File: rtl/alu_result_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_result_stage
// Purpose  : EX/MEM pipeline boundary for the ALU result. Registers the adder
//            result, destination register and qualified write enable; derives
//            N/Z/C/V from the adder's MSB carries and holds the architectural
//            condition-flag register; supplies a combinational zero detect for
//            CBZ/CBNZ resolution in EX.
// Ports    : clk, reset (sync, active-high)
//            ex_valid, ex_result[WIDTH], ex_cout_msb, ex_cin_msb,
//            ex_set_flags, ex_reg_write, ex_rd[5], stall, flush   (inputs)
//            mem_valid, mem_result[WIDTH], mem_rd[5], mem_reg_write,
//            flag_n, flag_z, flag_c, flag_v, ex_zero              (outputs)
//            perf_issued[32], perf_flag_updates[32]  (only with macro)
// Config   : `ALU_STAGE_PERF_EN adds two saturating 32-bit event counters.
// Revision : 1.0 - initial release
// ============================================================================
module alu_result_stage #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ex_valid,
    input  logic [WIDTH-1:0] ex_result,
    input  logic             ex_cout_msb,
    input  logic             ex_cin_msb,
    input  logic             ex_set_flags,
    input  logic             ex_reg_write,
    input  logic [4:0]       ex_rd,
    input  logic             stall,
    input  logic             flush,
    output logic             mem_valid,
    output logic [WIDTH-1:0] mem_result,
    output logic [4:0]       mem_rd,
    output logic             mem_reg_write,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v,
    output logic             ex_zero
`ifdef ALU_STAGE_PERF_EN
    ,
    output logic [31:0]      perf_issued,
    output logic [31:0]      perf_flag_updates
`endif
);

    localparam logic [4:0] C_XZR = 5'd31;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic w_normal;
    logic w_flag_load;
    logic w_zero;

    assign w_zero      = (ex_result == '0);
    assign w_normal    = !flush && !stall;
    assign w_flag_load = w_normal && ex_valid && ex_set_flags;
    assign ex_zero     = w_zero;

    // ------------------------------------------------------------------
    // Pipeline and flag state
    // ------------------------------------------------------------------
    logic             mem_valid_q,     mem_valid_d;
    logic [WIDTH-1:0] mem_result_q,    mem_result_d;
    logic [4:0]       mem_rd_q,        mem_rd_d;
    logic             mem_reg_write_q, mem_reg_write_d;
    logic [3:0]       flags_q,         flags_d;   // {N, Z, C, V}

    always_comb begin
        mem_valid_d     = mem_valid_q;
        mem_result_d    = mem_result_q;
        mem_rd_d        = mem_rd_q;
        mem_reg_write_d = mem_reg_write_q;
        flags_d         = flags_q;
        if (flush) begin
            // Bubble: architectural flags are intentionally left untouched.
            mem_valid_d     = 1'b0;
            mem_result_d    = '0;
            mem_rd_d        = '0;
            mem_reg_write_d = 1'b0;
        end else if (!stall) begin
            mem_valid_d     = ex_valid;
            mem_result_d    = ex_result;
            mem_rd_d        = ex_rd;
            // Writes to XZR are dropped here so MEM/WB never see them.
            mem_reg_write_d = ex_valid && ex_reg_write && (ex_rd != C_XZR);
        end
        if (w_flag_load) begin
            // The adder already produced borrow-as-carry for subtracts, so
            // C is taken straight from the MSB carry-out.
            flags_d = {ex_result[WIDTH-1], w_zero, ex_cout_msb,
                       ex_cin_msb ^ ex_cout_msb};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_valid_q     <= 1'b0;
            mem_result_q    <= '0;
            mem_rd_q        <= '0;
            mem_reg_write_q <= 1'b0;
            flags_q         <= '0;
        end else begin
            mem_valid_q     <= mem_valid_d;
            mem_result_q    <= mem_result_d;
            mem_rd_q        <= mem_rd_d;
            mem_reg_write_q <= mem_reg_write_d;
            flags_q         <= flags_d;
        end
    end

    assign mem_valid     = mem_valid_q;
    assign mem_result    = mem_result_q;
    assign mem_rd        = mem_rd_q;
    assign mem_reg_write = mem_reg_write_q;
    assign flag_n        = flags_q[3];
    assign flag_z        = flags_q[2];
    assign flag_c        = flags_q[1];
    assign flag_v        = flags_q[0];

`ifdef ALU_STAGE_PERF_EN
    // ------------------------------------------------------------------
    // Saturating event counters
    // ------------------------------------------------------------------
    localparam logic [31:0] C_CNT_MAX = 32'hFFFF_FFFF;

    logic [31:0] perf_issued_q, perf_issued_d;
    logic [31:0] perf_flag_updates_q, perf_flag_updates_d;

    always_comb begin
        perf_issued_d       = perf_issued_q;
        perf_flag_updates_d = perf_flag_updates_q;
        if (w_normal && ex_valid && (perf_issued_q != C_CNT_MAX)) begin
            perf_issued_d = perf_issued_q + 32'd1;
        end
        if (w_flag_load && (perf_flag_updates_q != C_CNT_MAX)) begin
            perf_flag_updates_d = perf_flag_updates_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_issued_q       <= '0;
            perf_flag_updates_q <= '0;
        end else begin
            perf_issued_q       <= perf_issued_d;
            perf_flag_updates_q <= perf_flag_updates_d;
        end
    end

    assign perf_issued       = perf_issued_q;
    assign perf_flag_updates = perf_flag_updates_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_result_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_result_stage
// Purpose  : Self-checking bench for alu_result_stage: directed scenarios
//            followed by randomized traffic, compared against a behavioural
//            model of the pipeline register, flag register and counters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_result_stage;

    localparam int WIDTH = 64;

    logic             clk = 1'b0;
    logic             reset;
    logic             ex_valid;
    logic [WIDTH-1:0] ex_result;
    logic             ex_cout_msb;
    logic             ex_cin_msb;
    logic             ex_set_flags;
    logic             ex_reg_write;
    logic [4:0]       ex_rd;
    logic             stall;
    logic             flush;
    logic             mem_valid;
    logic [WIDTH-1:0] mem_result;
    logic [4:0]       mem_rd;
    logic             mem_reg_write;
    logic             flag_n, flag_z, flag_c, flag_v;
    logic             ex_zero;
`ifdef ALU_STAGE_PERF_EN
    logic [31:0]      perf_issued;
    logic [31:0]      perf_flag_updates;
`endif

    alu_result_stage #(.WIDTH(WIDTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .ex_valid      (ex_valid),
        .ex_result     (ex_result),
        .ex_cout_msb   (ex_cout_msb),
        .ex_cin_msb    (ex_cin_msb),
        .ex_set_flags  (ex_set_flags),
        .ex_reg_write  (ex_reg_write),
        .ex_rd         (ex_rd),
        .stall         (stall),
        .flush         (flush),
        .mem_valid     (mem_valid),
        .mem_result    (mem_result),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .flag_n        (flag_n),
        .flag_z        (flag_z),
        .flag_c        (flag_c),
        .flag_v        (flag_v),
        .ex_zero       (ex_zero)
`ifdef ALU_STAGE_PERF_EN
        ,
        .perf_issued       (perf_issued),
        .perf_flag_updates (perf_flag_updates)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    logic             m_valid, m_rw, m_n, m_z, m_c, m_v;
    logic [WIDTH-1:0] m_result;
    logic [4:0]       m_rd;
    longint unsigned  m_issued, m_fupd;   // unbounded counts, clamped on compare

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sat32(input longint unsigned v);
        return (v > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
    endfunction

    // Architectural effect of one rising edge with the current EX inputs.
    task automatic model_edge();
        if (reset) begin
            m_valid = 0; m_rw = 0; m_result = '0; m_rd = '0;
            m_n = 0; m_z = 0; m_c = 0; m_v = 0;
            m_issued = 0; m_fupd = 0;
        end else if (flush) begin
            m_valid = 0; m_rw = 0; m_result = '0; m_rd = '0;
        end else if (!stall) begin
            m_valid  = ex_valid;
            m_result = ex_result;
            m_rd     = ex_rd;
            m_rw     = ex_valid && ex_reg_write && (ex_rd != 5'd31);
            if (ex_valid) m_issued++;
            if (ex_valid && ex_set_flags) begin
                m_n = ex_result[WIDTH-1];
                m_z = (ex_result == 0);
                m_c = ex_cout_msb;
                m_v = (ex_cin_msb != ex_cout_msb);
                m_fupd++;
            end
        end
    endtask

    task automatic check_all();
        chk("mem_valid",     {63'd0, mem_valid},     {63'd0, m_valid});
        chk("mem_result",    mem_result,             m_result);
        chk("mem_rd",        {59'd0, mem_rd},        {59'd0, m_rd});
        chk("mem_reg_write", {63'd0, mem_reg_write}, {63'd0, m_rw});
        chk("flags_nzcv",    {60'd0, flag_n, flag_z, flag_c, flag_v},
                             {60'd0, m_n, m_z, m_c, m_v});
`ifdef ALU_STAGE_PERF_EN
        chk("perf_issued",       {32'd0, perf_issued},       {32'd0, sat32(m_issued)});
        chk("perf_flag_updates", {32'd0, perf_flag_updates}, {32'd0, sat32(m_fupd)});
`endif
    endtask

    // Drive a full EX bundle at the falling edge, check ex_zero in the same cycle.
    task automatic drive(input logic rst, input logic v, input logic [63:0] res,
                         input logic co, input logic ci, input logic sf,
                         input logic rw, input logic [4:0] rd,
                         input logic st, input logic fl);
        @(negedge clk);
        reset = rst; ex_valid = v; ex_result = res; ex_cout_msb = co;
        ex_cin_msb = ci; ex_set_flags = sf; ex_reg_write = rw; ex_rd = rd;
        stall = st; flush = fl;
        #1;
        chk("ex_zero", {63'd0, ex_zero}, {63'd0, (res == 64'd0)});
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        reset = 1; ex_valid = 0; ex_result = '0; ex_cout_msb = 0; ex_cin_msb = 0;
        ex_set_flags = 0; ex_reg_write = 0; ex_rd = '0; stall = 0; flush = 0;

        // Reset held 3 cycles with live EX traffic: everything stays 0.
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 64'hDEAD_BEEF_0000_0001 + i, 1, 0, 1, 1, 5'd3, 0, 0);
            tick();
            chk("rst_mem_valid", {63'd0, mem_valid}, 64'd0);
            chk("rst_flags", {60'd0, flag_n, flag_z, flag_c, flag_v}, 64'd0);
        end

        // First normal edge captures EX.
        drive(0, 1, 64'h0000_1234_5678_9ABC, 0, 0, 0, 1, 5'd7, 0, 0);
        tick();
        chk("cap_result", mem_result, 64'h0000_1234_5678_9ABC);
        chk("cap_rw", {63'd0, mem_reg_write}, 64'd1);

        // SUBS 5-5: Z=1, C=1, N=0, V=0; ex_zero already high in EX.
        drive(0, 1, 64'd0, 1, 1, 1, 1, 5'd2, 0, 0);
        chk("subs_ex_zero", {63'd0, ex_zero}, 64'd1);
        tick();
        chk("subs_flags", {60'd0, flag_n, flag_z, flag_c, flag_v}, 64'b0110);

        // ADDS signed overflow: N=1, V=1, Z=0, C=0.
        drive(0, 1, 64'h8000_0000_0000_0000, 0, 1, 1, 1, 5'd4, 0, 0);
        tick();
        chk("adds_flags", {60'd0, flag_n, flag_z, flag_c, flag_v}, 64'b1001);

        // Plain ADD leaves flags alone.
        drive(0, 1, 64'd0, 1, 1, 0, 1, 5'd5, 0, 0);
        tick();
        chk("add_keep_flags", {60'd0, flag_n, flag_z, flag_c, flag_v}, 64'b1001);

        // Two stalled cycles with new set-flags EX: everything holds.
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, 64'd0, 1, 1, 1, 1, 5'd9, 1, 0);
            tick();
            chk("stall_rd", {59'd0, mem_rd}, 64'd5);
            chk("stall_flags", {60'd0, flag_n, flag_z, flag_c, flag_v}, 64'b1001);
        end
        drive(0, 1, 64'd0, 1, 1, 1, 1, 5'd9, 0, 0);
        tick();
        chk("unstall_rd", {59'd0, mem_rd}, 64'd9);
        chk("unstall_flags", {60'd0, flag_n, flag_z, flag_c, flag_v}, 64'b0110);

        // Flush with stall: bubble, flags unchanged.
        drive(0, 1, 64'h8000_0000_0000_0000, 0, 1, 1, 1, 5'd11, 1, 1);
        tick();
        chk("flush_valid", {63'd0, mem_valid}, 64'd0);
        chk("flush_rw", {63'd0, mem_reg_write}, 64'd0);
        chk("flush_flags", {60'd0, flag_n, flag_z, flag_c, flag_v}, 64'b0110);

        // Write to XZR suppressed.
        drive(0, 1, 64'h55, 0, 0, 0, 1, 5'd31, 0, 0);
        tick();
        chk("xzr_rw", {63'd0, mem_reg_write}, 64'd0);
        chk("xzr_valid", {63'd0, mem_valid}, 64'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 300; i++) begin
            logic [63:0] r;
            r = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) r = '0;
            drive(($urandom_range(0, 39) == 0), 1'($urandom), r, 1'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0));
            tick();
        end

`ifdef ALU_STAGE_PERF_EN
        // 4 valid issues (2 set flags) plus one stalled and one flushed cycle.
        drive(1, 0, 64'd0, 0, 0, 0, 0, 5'd0, 0, 0); tick();
        drive(0, 1, 64'd1, 0, 0, 1, 1, 5'd1, 0, 0); tick();
        drive(0, 1, 64'd2, 0, 0, 0, 1, 5'd2, 0, 0); tick();
        drive(0, 1, 64'd3, 0, 0, 1, 1, 5'd3, 1, 0); tick();
        drive(0, 1, 64'd4, 0, 0, 1, 1, 5'd4, 0, 1); tick();
        drive(0, 1, 64'd5, 0, 0, 1, 1, 5'd5, 0, 0); tick();
        drive(0, 1, 64'd6, 0, 0, 0, 1, 5'd6, 0, 0); tick();
        chk("perf_issued_4", {32'd0, perf_issued}, 64'd4);
        chk("perf_fupd_2", {32'd0, perf_flag_updates}, 64'd2);

        // Preload near the top and confirm saturation.
        @(negedge clk);
        force dut.perf_issued_q = 32'hFFFF_FFFE;
        force dut.perf_flag_updates_q = 32'hFFFF_FFFE;
        #1;
        release dut.perf_issued_q;
        release dut.perf_flag_updates_q;
        m_issued = 64'hFFFF_FFFE;
        m_fupd   = 64'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 64'd7, 0, 0, 1, 1, 5'd7, 0, 0);
            tick();
        end
        chk("perf_issued_sat", {32'd0, perf_issued}, 64'hFFFF_FFFF);
        chk("perf_fupd_sat", {32'd0, perf_flag_updates}, 64'hFFFF_FFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_result_stage.md
# alu_result_stage

- Registers the EX-stage adder/ALU result into the EX/MEM pipeline boundary.
- Derives N/Z/C/V from the ripple chain's MSB carries and holds the architectural condition-flag register.
- Applies stall/flush control and provides a combinational zero signal for CBZ resolution in EX.
- Sits directly downstream of the bit-sliced full-adder chain; its outputs feed the MEM stage and the branch unit.

## Interface

Parameters:
- `WIDTH`, default 64: datapath width.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `ex_valid`, in, 1: EX holds a real instruction.
- `ex_result`, in, WIDTH: sum/result bits from the adder chain.
- `ex_cout_msb`, in, 1: carry out of bit WIDTH-1.
- `ex_cin_msb`, in, 1: carry into bit WIDTH-1.
- `ex_set_flags`, in, 1: instruction is ADDS/SUBS-type.
- `ex_reg_write`, in, 1: instruction writes the register file.
- `ex_rd`, in, 5: destination register.
- `stall`, in, 1: hold all state.
- `flush`, in, 1: insert a bubble.
- `mem_valid`, out, 1: registered valid.
- `mem_result`, out, WIDTH: registered result.
- `mem_rd`, out, 5: registered destination.
- `mem_reg_write`, out, 1: registered, qualified write enable.
- `flag_n`, `flag_z`, `flag_c`, `flag_v`, out, 1 each: architectural flags.
- `ex_zero`, out, 1: combinational, ex_result == 0.

## Operation

- Flag derivation:
  - N = ex_result[WIDTH-1].
  - Z = (ex_result == 0).
  - C = ex_cout_msb.
  - V = ex_cin_msb ^ ex_cout_msb.
  - Subtract carry semantics come from the adder (B inverted, cin=1), so no extra inversion here.
- Update priority each edge: reset > flush > stall > normal.
- Reset: every registered output is 0, namely mem_valid, mem_result, mem_rd, mem_reg_write and all four flags.
- Flush, with or without stall:
  - mem_valid and mem_reg_write go to 0.
  - mem_result and mem_rd go to 0.
  - Flags are unchanged.
- Stall without flush: all registers hold, flags included.
- Normal edge:
  - mem_valid ← ex_valid.
  - mem_result ← ex_result.
  - mem_rd ← ex_rd.
  - mem_reg_write ← ex_valid & ex_reg_write & (ex_rd != 31), so writes to XZR are suppressed.
- Flag register: loads all four derived flags only on a normal edge with ex_valid & ex_set_flags. Otherwise all four hold. There are no partial updates.
- ex_zero is purely combinational and does not depend on ex_valid, stall or flush.

## Timing

- Result latency: 1 cycle, EX edge n appears at MEM outputs after edge n.
- Flags written at edge n are visible to the instruction in EX during cycle n+1. A B.cond directly following ADDS/SUBS needs no bypass.
- ex_zero is valid in the same cycle as ex_result, after combinational settle only.
- Reset asserted mid-stream clears state at the next edge regardless of stall or flush. Outputs stay 0 while reset is held.
- Back-to-back set-flags instructions: each normal edge overwrites the flags, and the last one wins.

## Configuration

- Macro `ALU_STAGE_PERF_EN`.
- Defined: adds two 32-bit outputs, `perf_issued` and `perf_flag_updates`.
  - Counters reset to 0.
  - `perf_issued` increments on each normal edge with ex_valid.
  - `perf_flag_updates` increments on each flag-register load.
  - Both saturate at 0xFFFFFFFF.
  - Neither changes on stall or flush.
- Undefined: the ports and counters do not exist. Behaviour is otherwise identical.

## Test plan

- Reset, then hold reset 3 cycles with ex_valid=1 → all MEM outputs and all flags are 0 throughout. The first normal edge after release captures EX.
- SUBS 5−5 (ex_result=0, cout_msb=1, cin_msb=1, set_flags=1) → next cycle flag_z=1, flag_c=1, flag_n=0, flag_v=0, mem_result=0, and ex_zero=1 in the same cycle.
- ADDS 0x7FFF_FFFF_FFFF_FFFF+1 (result 0x8000…0, cin_msb=1, cout_msb=0) → N=1, V=1, Z=0, C=0. A following ADD with set_flags=0 leaves the flags unchanged.
- Stall for 2 cycles with new EX values and set_flags=1 → MEM outputs and flags hold their previous values. Release → the current EX is captured.
- flush=1 and stall=1 together with ex_valid=1, ex_reg_write=1, set_flags=1 → mem_valid=0, mem_reg_write=0, flags unchanged. Separately, ex_rd=31 with reg_write=1 → mem_reg_write=0.
- With `ALU_STAGE_PERF_EN` defined: 4 valid instructions, 2 of them set_flags, plus 1 stalled and 1 flushed cycle → perf_issued=4, perf_flag_updates=2. Preload near 0xFFFFFFFF → counters saturate and do not wrap.
